// File: rtl/alu_toggle_monitor.sv
// ---------------------------------------------------------------------------
// alu_toggle_monitor
//
// Watches the 16-bit ALU result and its five flags as one 21-bit vector
// {z, s, cr, ze, p, o}. For each valid sample it counts the bits that changed
// since the previous valid sample. Over a window of WINDOW counted samples it
// reports the saturated sum of those counts and the largest single count.
// Each window result is held in a 1-deep valid/ready output register.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   clr          in   1      synchronous clear, highest priority
//   in_valid     in   1      {z,s,cr,ze,p,o} valid this cycle
//   z            in   16     ALU result
//   s,cr,ze,p,o  in   1      ALU flags: sign, carry, zero, parity, overflow
//   out_valid    out  1      window result available
//   out_ready    in   1      consumer accepts result
//   win_toggles  out  ACC_W  saturated toggle total for the window
//   win_peak     out  5      largest per-sample toggle count in the window
//   ovf          out  1      sticky: a window result was dropped
//   primed       out  1      a reference sample is held
// ---------------------------------------------------------------------------
module alu_toggle_monitor #(
    parameter int WINDOW = 16,
    parameter int ACC_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [15:0]      z,
    input  logic             s,
    input  logic             cr,
    input  logic             ze,
    input  logic             p,
    input  logic             o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] win_toggles,
    output logic [4:0]       win_peak,
    output logic             ovf,
    output logic             primed
);

    localparam int CNT_W = $clog2(WINDOW);

    typedef enum logic {
        UNPRIMED = 1'b0,
        ACCUM    = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [20:0]       prev;
    logic [ACC_W-1:0]  acc;
    logic [4:0]        peak;
    logic [CNT_W-1:0]  cnt;

    logic [20:0]       vec;
    logic [4:0]        d;
    logic [ACC_W-1:0]  acc_next;
    logic [4:0]        peak_next;
    logic              counting;
    logic              win_end;

    function automatic logic [4:0] popcount21(input logic [20:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 21; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Sum with one spare bit; any carry into it means the total no longer
    // fits and the accumulator pins at all-ones.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [4:0]       b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {{(ACC_W-4){1'b0}}, b};
        if (sum[ACC_W]) begin
            return '1;
        end
        return sum[ACC_W-1:0];
    endfunction

    function automatic logic [4:0] max5(input logic [4:0] a, input logic [4:0] b);
        return (a > b) ? a : b;
    endfunction

    assign vec       = {z, s, cr, ze, p, o};
    assign d         = popcount21(vec ^ prev);
    assign acc_next  = sat_add(acc, d);
    assign peak_next = max5(peak, d);
    assign counting  = !clr && in_valid && (state == ACCUM);
    assign win_end   = counting && (cnt == CNT_W'(WINDOW - 1));
    assign primed    = (state == ACCUM);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNPRIMED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = UNPRIMED;
        end else if (state == UNPRIMED && in_valid) begin
            state_next = ACCUM;
        end
    end

    // Window accumulation. The sample that closes a window also becomes the
    // reference for the next one, so windows run back-to-back with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            acc  <= '0;
            peak <= '0;
            cnt  <= '0;
        end else if (clr) begin
            acc  <= '0;
            peak <= '0;
            cnt  <= '0;
        end else if (in_valid) begin
            prev <= vec;
            if (win_end) begin
                acc  <= '0;
                peak <= '0;
                cnt  <= '0;
            end else if (counting) begin
                acc  <= acc_next;
                peak <= peak_next;
                cnt  <= cnt + CNT_W'(1);
            end
        end
    end

    // Output register: a finished window is loaded only if the slot is empty
    // or being drained this very cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            win_toggles <= '0;
            win_peak    <= '0;
            ovf         <= 1'b0;
        end else if (clr) begin
            out_valid   <= 1'b0;
            win_toggles <= '0;
            win_peak    <= '0;
            ovf         <= 1'b0;
        end else if (win_end) begin
            if (!out_valid || out_ready) begin
                out_valid   <= 1'b1;
                win_toggles <= acc_next;
                win_peak    <= peak_next;
            end else begin
                ovf <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_toggle_monitor.sv
module tb_alu_toggle_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [15:0] z;
    logic [4:0]  f;
    logic        out_ready;
    logic        s, cr, ze, p, o;

    assign s  = f[4];
    assign cr = f[3];
    assign ze = f[2];
    assign p  = f[1];
    assign o  = f[0];

    logic        ov16, ovf16, pr16;
    logic [15:0] tog16;
    logic [4:0]  pk16;
    logic        ov8, ovf8, pr8;
    logic [7:0]  tog8;
    logic [4:0]  pk8;

    alu_toggle_monitor #(.WINDOW(16), .ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .z(z), .s(s), .cr(cr), .ze(ze), .p(p), .o(o),
        .out_valid(ov16), .out_ready(out_ready), .win_toggles(tog16),
        .win_peak(pk16), .ovf(ovf16), .primed(pr16)
    );

    alu_toggle_monitor #(.WINDOW(16), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .z(z), .s(s), .cr(cr), .ze(ze), .p(p), .o(o),
        .out_valid(ov8), .out_ready(out_ready), .win_toggles(tog8),
        .win_peak(pk8), .ovf(ovf8), .primed(pr8)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [15:0] pz;
        logic [4:0]  pf;
        logic [15:0] az;
        logic [4:0]  af;
        logic [15:0] bz;
        logic [4:0]  bf;
        int          exp16;
        int          exp8;
        int          peak;
    } win_vec_t;

    win_vec_t tbl[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic sample(input logic [15:0] zz, input logic [4:0] ff);
        in_valid = 1'b1;
        z        = zz;
        f        = ff;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic alt(input logic [15:0] az, input logic [4:0] af,
                       input logic [15:0] bz, input logic [4:0] bf, input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) sample(az, af);
            else            sample(bz, bf);
        end
    endtask

    initial begin
        // name, prime z/f, even-sample z/f, odd-sample z/f, total(16b), total(8b), peak
        tbl[0] = '{"alt_ffff",   16'h0000, 5'h00, 16'hFFFF, 5'h00, 16'h0000, 5'h00, 256, 255, 16};
        tbl[1] = '{"constant",   16'h4F86, 5'h00, 16'h4F86, 5'h00, 16'h4F86, 5'h00,   0,   0,  0};
        tbl[2] = '{"all_ones",   16'h0000, 5'h00, 16'hFFFF, 5'h1F, 16'h0000, 5'h00, 336, 255, 21};
        tbl[3] = '{"alt_aaaa",   16'h4F86, 5'h00, 16'hAAAA, 5'h00, 16'h4F86, 5'h00, 128, 128,  8};
        tbl[4] = '{"flag_mix",   16'h0000, 5'h00, 16'h0001, 5'h10, 16'h0000, 5'h01,  47,  47,  3};

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; z = '0; f = '0; out_ready = 1'b1;
        tick(); tick();
        chk("reset_out_valid", int'(ov16), 0);
        chk("reset_toggles",   int'(tog16), 0);
        chk("reset_peak",      int'(pk16), 0);
        chk("reset_ovf",       int'(ovf16), 0);
        chk("reset_primed",    int'(pr16), 0);
        #3 rst_n = 1'b1;
        tick();

        // Table-driven single windows, consumer always ready
        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b1;
            do_clr();
            chk({tbl[k].name, "_unprimed"}, int'(pr16), 0);
            sample(tbl[k].pz, tbl[k].pf);
            chk({tbl[k].name, "_primed"}, int'(pr16), 1);
            alt(tbl[k].az, tbl[k].af, tbl[k].bz, tbl[k].bf, 15);
            chk({tbl[k].name, "_early_valid"}, int'(ov16), 0);
            sample(tbl[k].bz, tbl[k].bf);
            chk({tbl[k].name, "_valid"},   int'(ov16), 1);
            chk({tbl[k].name, "_tog16"},   int'(tog16), tbl[k].exp16);
            chk({tbl[k].name, "_peak16"},  int'(pk16), tbl[k].peak);
            chk({tbl[k].name, "_tog8"},    int'(tog8), tbl[k].exp8);
            chk({tbl[k].name, "_peak8"},   int'(pk8), tbl[k].peak);
            chk({tbl[k].name, "_ovf"},     int'(ovf16), 0);
            tick();
            chk({tbl[k].name, "_drained"}, int'(ov16), 0);
        end

        // Back-pressure across two windows: first result held, second dropped
        do_clr();
        out_ready = 1'b0;
        sample(16'h0000, 5'h00);
        alt(16'hFFFF, 5'h00, 16'h0000, 5'h00, 16);
        chk("bp_valid1", int'(ov16), 1);
        chk("bp_tog1",   int'(tog16), 256);
        chk("bp_ovf1",   int'(ovf16), 0);
        alt(16'h0001, 5'h00, 16'h0000, 5'h00, 8);
        chk("bp_hold_mid", int'(tog16), 256);
        alt(16'h0001, 5'h00, 16'h0000, 5'h00, 8);
        chk("bp_valid2", int'(ov16), 1);
        chk("bp_tog2",   int'(tog16), 256);
        chk("bp_peak2",  int'(pk16), 16);
        chk("bp_ovf2",   int'(ovf16), 1);
        out_ready = 1'b1;
        tick();
        chk("bp_drain",       int'(ov16), 0);
        chk("bp_ovf_sticky",  int'(ovf16), 1);
        do_clr();
        chk("bp_ovf_cleared", int'(ovf16), 0);

        // Window end coinciding with the handshake
        out_ready = 1'b0;
        sample(16'h4F86, 5'h00);
        alt(16'hAAAA, 5'h00, 16'h4F86, 5'h00, 16);
        chk("hs_valid1", int'(ov16), 1);
        chk("hs_tog1",   int'(tog16), 128);
        chk("hs_peak1",  int'(pk16), 8);
        alt(16'h4F86, 5'h00, 16'h4F86, 5'h00, 15);
        chk("hs_hold", int'(tog16), 128);
        out_ready = 1'b1;
        sample(16'hAAAA, 5'h00);
        chk("hs_valid2", int'(ov16), 1);
        chk("hs_tog2",   int'(tog16), 8);
        chk("hs_peak2",  int'(pk16), 8);
        chk("hs_ovf",    int'(ovf16), 0);
        tick();
        chk("hs_drain",  int'(ov16), 0);

        // Asynchronous reset mid-window, then clear, then a clean full window
        out_ready = 1'b1;
        sample(16'h0000, 5'h00);
        alt(16'hFFFF, 5'h00, 16'h0000, 5'h00, 5);
        chk("ar_primed_before", int'(pr16), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_primed",  int'(pr16), 0);
        chk("ar_valid",   int'(ov16), 0);
        chk("ar_toggles", int'(tog16), 0);
        chk("ar_peak",    int'(pk16), 0);
        chk("ar_ovf",     int'(ovf16), 0);
        #1 rst_n = 1'b1;
        do_clr();
        chk("ar_clr_primed", int'(pr16), 0);
        sample(16'h0000, 5'h00);
        alt(16'hFFFF, 5'h00, 16'h0000, 5'h00, 15);
        chk("ar_no_early", int'(ov16), 0);
        sample(16'h0000, 5'h00);
        chk("ar_valid_full", int'(ov16), 1);
        chk("ar_tog_full",   int'(tog16), 256);
        chk("ar_peak_full",  int'(pk16), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
